// File: rtl/ascii_font_pkg.sv
// ascii_font_pkg: IBM VGA 8x16 font (CP437, codes 0x00-0x7F).
// Glyph rows packed MSB-first: row 0 is bits [127:120].
package ascii_font_pkg;

  localparam int FONT_ROWS  = 16;
  localparam int FONT_COLS  = 8;
  localparam int FONT_CHARS = 128;

  typedef logic [FONT_COLS-1:0] glyph_row_t;
  typedef logic [FONT_ROWS*FONT_COLS-1:0] glyph_t;

  localparam glyph_t FONT_GLYPHS [FONT_CHARS] = '{
    128'h0000_0000_0000_0000_0000_0000_0000_0000, // 00
    128'h0000_7e81_a581_81bd_9981_817e_0000_0000, // 01
    128'h0000_7eff_dbff_ffc3_e7ff_ff7e_0000_0000, // 02
    128'h0000_0000_6cfe_fefe_fe7c_3810_0000_0000, // 03
    128'h0000_0000_1038_7cfe_7c38_1000_0000_0000, // 04
    128'h0000_0018_3c3c_e7e7_e718_183c_0000_0000, // 05
    128'h0000_0018_3c7e_ffff_7e18_183c_0000_0000, // 06
    128'h0000_0000_0000_183c_3c18_0000_0000_0000, // 07
    128'hffff_ffff_ffff_e7c3_c3e7_ffff_ffff_ffff, // 08
    128'h0000_0000_003c_6642_4266_3c00_0000_0000, // 09
    128'hffff_ffff_ffc3_99bd_bd99_c3ff_ffff_ffff, // 0a
    128'h0000_1e0e_1a32_78cc_cccc_cc78_0000_0000, // 0b
    128'h0000_3c66_6666_663c_187e_1818_0000_0000, // 0c
    128'h0000_3f33_3f30_3030_3070_f0e0_0000_0000, // 0d
    128'h0000_7f63_7f63_6363_6367_e7e6_c000_0000, // 0e
    128'h0000_0018_18db_3ce7_3cdb_1818_0000_0000, // 0f
    128'h0080_c0e0_f0f8_fef8_f0e0_c080_0000_0000, // 10
    128'h0002_060e_1e3e_fe3e_1e0e_0602_0000_0000, // 11
    128'h0000_183c_7e18_1818_7e3c_1800_0000_0000, // 12
    128'h0000_6666_6666_6666_6600_6666_0000_0000, // 13
    128'h0000_7fdb_dbdb_7b1b_1b1b_1b1b_0000_0000, // 14
    128'h007c_c660_386c_c6c6_6c38_0cc6_7c00_0000, // 15
    128'h0000_0000_0000_0000_fefe_fefe_0000_0000, // 16
    128'h0000_183c_7e18_1818_7e3c_187e_0000_0000, // 17
    128'h0000_183c_7e18_1818_1818_1818_0000_0000, // 18
    128'h0000_1818_1818_1818_187e_3c18_0000_0000, // 19
    128'h0000_0000_0018_0cfe_0c18_0000_0000_0000, // 1a
    128'h0000_0000_0030_60fe_6030_0000_0000_0000, // 1b
    128'h0000_0000_0000_c0c0_c0fe_0000_0000_0000, // 1c
    128'h0000_0000_0028_6cfe_6c28_0000_0000_0000, // 1d
    128'h0000_0000_1038_387c_7cfe_fe00_0000_0000, // 1e
    128'h0000_0000_fefe_7c7c_3838_1000_0000_0000, // 1f
    128'h0000_0000_0000_0000_0000_0000_0000_0000, // 20
    128'h0000_183c_3c3c_1818_1800_1818_0000_0000, // 21
    128'h0066_6666_2400_0000_0000_0000_0000_0000, // 22
    128'h0000_006c_6cfe_6c6c_6cfe_6c6c_0000_0000, // 23
    128'h1818_7cc6_c2c0_7c06_0686_c67c_1818_0000, // 24
    128'h0000_0000_c2c6_0c18_3060_c686_0000_0000, // 25
    128'h0000_386c_6c38_76dc_cccc_cc76_0000_0000, // 26
    128'h0030_3030_6000_0000_0000_0000_0000_0000, // 27
    128'h0000_0c18_3030_3030_3030_180c_0000_0000, // 28
    128'h0000_3018_0c0c_0c0c_0c0c_1830_0000_0000, // 29
    128'h0000_0000_0066_3cff_3c66_0000_0000_0000, // 2a
    128'h0000_0000_0018_187e_1818_0000_0000_0000, // 2b
    128'h0000_0000_0000_0000_0018_1818_3000_0000, // 2c
    128'h0000_0000_0000_00fe_0000_0000_0000_0000, // 2d
    128'h0000_0000_0000_0000_0000_1818_0000_0000, // 2e
    128'h0000_0000_0206_0c18_3060_c080_0000_0000, // 2f
    128'h0000_386c_c6c6_d6d6_c6c6_6c38_0000_0000, // 30
    128'h0000_1838_7818_1818_1818_187e_0000_0000, // 31
    128'h0000_7cc6_060c_1830_60c0_c6fe_0000_0000, // 32
    128'h0000_7cc6_0606_3c06_0606_c67c_0000_0000, // 33
    128'h0000_0c1c_3c6c_ccfe_0c0c_0c1e_0000_0000, // 34
    128'h0000_fec0_c0c0_fc06_0606_c67c_0000_0000, // 35
    128'h0000_3860_c0c0_fcc6_c6c6_c67c_0000_0000, // 36
    128'h0000_fec6_0606_0c18_3030_3030_0000_0000, // 37
    128'h0000_7cc6_c6c6_7cc6_c6c6_c67c_0000_0000, // 38
    128'h0000_7cc6_c6c6_7e06_0606_0c78_0000_0000, // 39
    128'h0000_0000_1818_0000_0018_1800_0000_0000, // 3a
    128'h0000_0000_1818_0000_0018_1830_0000_0000, // 3b
    128'h0000_0006_0c18_3060_3018_0c06_0000_0000, // 3c
    128'h0000_0000_007e_0000_7e00_0000_0000_0000, // 3d
    128'h0000_0060_3018_0c06_0c18_3060_0000_0000, // 3e
    128'h0000_7cc6_c60c_1818_1800_1818_0000_0000, // 3f
    128'h0000_007c_c6c6_dede_dedc_c07c_0000_0000, // 40
    128'h0000_1038_6cc6_c6fe_c6c6_c6c6_0000_0000, // 41
    128'h0000_fc66_6666_7c66_6666_66fc_0000_0000, // 42
    128'h0000_3c66_c2c0_c0c0_c0c2_663c_0000_0000, // 43
    128'h0000_f86c_6666_6666_6666_6cf8_0000_0000, // 44
    128'h0000_fe66_6268_7868_6062_66fe_0000_0000, // 45
    128'h0000_fe66_6268_7868_6060_60f0_0000_0000, // 46
    128'h0000_3c66_c2c0_c0de_c6c6_663a_0000_0000, // 47
    128'h0000_c6c6_c6c6_fec6_c6c6_c6c6_0000_0000, // 48
    128'h0000_3c18_1818_1818_1818_183c_0000_0000, // 49
    128'h0000_1e0c_0c0c_0c0c_cccc_cc78_0000_0000, // 4a
    128'h0000_e666_666c_7878_6c66_66e6_0000_0000, // 4b
    128'h0000_f060_6060_6060_6062_66fe_0000_0000, // 4c
    128'h0000_c6ee_fefe_d6c6_c6c6_c6c6_0000_0000, // 4d
    128'h0000_c6e6_f6fe_dece_c6c6_c6c6_0000_0000, // 4e
    128'h0000_7cc6_c6c6_c6c6_c6c6_c67c_0000_0000, // 4f
    128'h0000_fc66_6666_7c60_6060_60f0_0000_0000, // 50
    128'h0000_7cc6_c6c6_c6c6_c6d6_de7c_0c0e_0000, // 51
    128'h0000_fc66_6666_7c6c_6666_66e6_0000_0000, // 52
    128'h0000_7cc6_c660_380c_06c6_c67c_0000_0000, // 53
    128'h0000_7e7e_5a18_1818_1818_183c_0000_0000, // 54
    128'h0000_c6c6_c6c6_c6c6_c6c6_c67c_0000_0000, // 55
    128'h0000_c6c6_c6c6_c6c6_c66c_3810_0000_0000, // 56
    128'h0000_c6c6_c6c6_d6d6_d6fe_ee6c_0000_0000, // 57
    128'h0000_c6c6_6c7c_3838_7c6c_c6c6_0000_0000, // 58
    128'h0000_6666_6666_3c18_1818_183c_0000_0000, // 59
    128'h0000_fec6_860c_1830_60c2_c6fe_0000_0000, // 5a
    128'h0000_3c30_3030_3030_3030_303c_0000_0000, // 5b
    128'h0000_0080_c0e0_7038_1c0e_0602_0000_0000, // 5c
    128'h0000_3c0c_0c0c_0c0c_0c0c_0c3c_0000_0000, // 5d
    128'h1038_6cc6_0000_0000_0000_0000_0000_0000, // 5e
    128'h0000_0000_0000_0000_0000_0000_00ff_0000, // 5f
    128'h0030_180c_0000_0000_0000_0000_0000_0000, // 60
    128'h0000_0000_0078_0c7c_cccc_cc76_0000_0000, // 61
    128'h0000_e060_6078_6c66_6666_667c_0000_0000, // 62
    128'h0000_0000_007c_c6c0_c0c0_c67c_0000_0000, // 63
    128'h0000_1c0c_0c3c_6ccc_cccc_cc76_0000_0000, // 64
    128'h0000_0000_007c_c6fe_c0c0_c67c_0000_0000, // 65
    128'h0000_386c_6460_f060_6060_60f0_0000_0000, // 66
    128'h0000_0000_0076_cccc_cccc_cc7c_0ccc_7800, // 67
    128'h0000_e060_606c_7666_6666_66e6_0000_0000, // 68
    128'h0000_1818_0038_1818_1818_183c_0000_0000, // 69
    128'h0000_0606_000e_0606_0606_0606_6666_3c00, // 6a
    128'h0000_e060_6066_6c78_786c_66e6_0000_0000, // 6b
    128'h0000_3818_1818_1818_1818_183c_0000_0000, // 6c
    128'h0000_0000_00ec_fed6_d6d6_d6c6_0000_0000, // 6d
    128'h0000_0000_00dc_6666_6666_6666_0000_0000, // 6e
    128'h0000_0000_007c_c6c6_c6c6_c67c_0000_0000, // 6f
    128'h0000_0000_00dc_6666_6666_667c_6060_f000, // 70
    128'h0000_0000_0076_cccc_cccc_cc7c_0c0c_1e00, // 71
    128'h0000_0000_00dc_7666_6060_60f0_0000_0000, // 72
    128'h0000_0000_007c_c660_380c_c67c_0000_0000, // 73
    128'h0000_1030_30fc_3030_3030_361c_0000_0000, // 74
    128'h0000_0000_00cc_cccc_cccc_cc76_0000_0000, // 75
    128'h0000_0000_0066_6666_6666_3c18_0000_0000, // 76
    128'h0000_0000_00c6_c6d6_d6d6_fe6c_0000_0000, // 77
    128'h0000_0000_00c6_6c38_3838_6cc6_0000_0000, // 78
    128'h0000_0000_00c6_c6c6_c6c6_c67e_060c_f800, // 79
    128'h0000_0000_00fe_cc18_3060_c6fe_0000_0000, // 7a
    128'h0000_0e18_1818_7018_1818_180e_0000_0000, // 7b
    128'h0000_1818_1818_0018_1818_1818_0000_0000, // 7c
    128'h0000_7018_1818_0e18_1818_1870_0000_0000, // 7d
    128'h0076_dc00_0000_0000_0000_0000_0000_0000, // 7e
    128'h0000_0000_1038_6cc6_c6c6_fe00_0000_0000  // 7f
  };

  function automatic glyph_row_t font_row(
    input logic [6:0] ch,
    input logic [3:0] row
  );
    glyph_t g;
    int     sh;
    g  = FONT_GLYPHS[ch];
    sh = (FONT_ROWS - 1 - int'(row)) * FONT_COLS;
    return g[sh +: FONT_COLS];
  endfunction

endpackage

// File: rtl/ascii_glyph_rom.sv
// ascii_glyph_rom: registered 8x16 glyph-row lookup, {char,row} address.
// Optional ASCII_ROM_CASE_FOLD_EN maps lowercase to uppercase glyphs.
module ascii_glyph_rom
  import ascii_font_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
);

  logic [6:0]            ch;
  logic [3:0]            row;
  logic [DATA_WIDTH-1:0] data_d;
  logic [DATA_WIDTH-1:0] data_q;

  // Split the address and optionally fold lowercase onto uppercase
  always_comb begin
    ch  = addr[10:4];
    row = addr[3:0];
`ifdef ASCII_ROM_CASE_FOLD_EN
    if (ch >= 7'h61 && ch <= 7'h7a) begin
      ch = ch - 7'h20;
    end
`endif
  end

  // Next output row: table lookup, or zero while reset is held low
  always_comb begin
    data_d = '0;
    if (reset) begin
      data_d = font_row(ch, row);
    end
  end

  // Output register gives the single cycle of read latency
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: tb/tb_ascii_glyph_rom.sv
// tb_ascii_glyph_rom: directed checks of the glyph ROM.
// Expected rows are hand-copied from the VGA 8x16 font.
module tb_ascii_glyph_rom;

  logic        clk;
  logic        reset;
  logic [10:0] addr;
  logic [7:0]  data;

  int total = 0;
  int bad   = 0;

  ascii_glyph_rom dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .data  (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] exp);
    total++;
    assert (data === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, data, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_a   [16];
  logic [7:0] exp_l   [16];
  logic [7:0] exp_one [16];
  logic [7:0] fold_exp;
  logic [7:0] fold2_exp;
  logic [7:0] prev;
  int         xbad;

  initial begin
    exp_a   = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6c, 8'hc6, 8'hc6, 8'hfe,
                8'hc6, 8'hc6, 8'hc6, 8'hc6, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_l   = '{8'h00, 8'h00, 8'hf0, 8'h60, 8'h60, 8'h60, 8'h60, 8'h60,
                8'h60, 8'h62, 8'h66, 8'hfe, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_one = '{8'h00, 8'h00, 8'h18, 8'h38, 8'h78, 8'h18, 8'h18, 8'h18,
                8'h18, 8'h18, 8'h18, 8'h7e, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef ASCII_ROM_CASE_FOLD_EN
    fold_exp  = 8'h6c;
    fold2_exp = 8'h10;
`else
    fold_exp  = 8'h00;
    fold2_exp = 8'h00;
`endif

    // reset held low with a live address
    reset = 1'b0;
    addr  = 11'h414;
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_zero", 8'h00);
    end
    reset = 1'b1;
    step();
    check("reset_release", 8'h6c);

    // 'A' rows 0..15
    for (int r = 0; r < 16; r++) begin
      addr = {7'h41, 4'(r)};
      step();
      check($sformatf("A_row%0d", r), exp_a[r]);
    end

    // 'L' rows 0..15
    for (int r = 0; r < 16; r++) begin
      addr = {7'h4c, 4'(r)};
      step();
      check($sformatf("L_row%0d", r), exp_l[r]);
    end

    // '1' rows and space rows
    for (int r = 0; r < 16; r++) begin
      addr = {7'h31, 4'(r)};
      step();
      check($sformatf("one_row%0d", r), exp_one[r]);
    end
    for (int r = 0; r < 16; r++) begin
      addr = {7'h20, 4'(r)};
      step();
      check($sformatf("space_row%0d", r), 8'h00);
    end

    addr = 11'h4cb;
    step();
    check("L_row11", 8'hfe);

    // alternate addresses: output must lag exactly one edge
    prev = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      addr = (i % 2 == 0) ? 11'h414 : 11'h4cb;
      #1;
      check("toggle_old", prev);
      step();
      prev = (i % 2 == 0) ? 8'h6c : 8'hfe;
      check("toggle_new", prev);
    end

    // held address keeps data stable
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold", 8'hfe);
    end

    // row wrap across a code boundary ('0' row 15 -> '1' row 0)
    addr = 11'h30f;
    step();
    check("wrap_row15", 8'h00);
    addr = addr + 11'd1;
    step();
    check("wrap_next_row0", 8'h00);
    addr = addr + 11'd2;
    step();
    check("wrap_next_row2", 8'h18);

    // other spot rows, incl. control codes and descenders
    addr = 11'h306;
    step();
    check("zero_row6", 8'hd6);
    addr = 11'h7fa;
    step();
    check("del_row10", 8'hfe);
    addr = 11'h01a;
    step();
    check("smile_row10", 8'h81);
    addr = 11'h5fd;
    step();
    check("underscore_row13", 8'hff);
    addr = 11'h67e;
    step();
    check("g_row14", 8'h78);
    addr = 11'h7ff;
    step();
    check("del_row15", 8'h00);

    // lowercase handling, with or without folding
    addr = 11'h614;
    step();
    check("fold_a_row4", fold_exp);
    addr = 11'h612;
    step();
    check("fold_a_row2", fold2_exp);
    addr = 11'h7b2;
    step();
    check("brace_row2", 8'h0e);

    // reset asserted mid-stream, then released
    reset = 1'b0;
    addr  = 11'h4cb;
    step();
    check("midreset_zero", 8'h00);
    reset = 1'b1;
    step();
    check("midreset_release", 8'hfe);

    // every address gives a known value
    xbad = 0;
    for (int a = 0; a < 2048; a++) begin
      addr = 11'(a);
      step();
      if ($isunknown(data)) xbad++;
    end
    total++;
    assert (xbad === 0) else begin
      bad++;
      $error("FAIL xfree observed=%0d expected=0", xbad);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
